config_word_loader: RTL and testbench

Sequences a session of 32-bit configuration words from a valid/ready stream into the bank of transparent configuration latches. It sits directly upstream of the latch bank and drives that bank's data bus and one-hot per-word enables. Each enable pulse is framed by setup and hold cycles so the latch data is stable on both enable edges. A session ends with a trailing XOR checksum word, and the block reports done and error status.

---
 rtl/config_word_loader_if.sv | 40 ++++
 rtl/config_word_loader.sv | 114 +++++++++++
 tb/tb_config_word_loader.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/config_word_loader_if.sv
// config_word_loader_if
//   Bundles the configuration loader's stream input, latch-bank outputs and
//   session status into one interface.
//   master : drives io_start / io_in_valid / io_in_bits; observes the rest.
//   slave  : the loader itself.
//   Signals:
//     io_start                              begin a session (sampled in IDLE only)
//     io_in_valid / io_in_ready / io_in_bits  valid/ready word stream
//     io_d_out                              data bus to the latch bank
//     io_configs_en                         one-hot latch enables
//     io_word_idx                           index of the current word
//     io_busy / io_done / io_error          session status
interface config_word_loader_if #(
   parameter int NUM_WORDS = 46,
   parameter int WORD_W    = 32,
   parameter int IDX_W     = 6
);
   logic                 io_start;
   logic                 io_in_valid;
   logic                 io_in_ready;
   logic [WORD_W-1:0]    io_in_bits;
   logic [WORD_W-1:0]    io_d_out;
   logic [NUM_WORDS-1:0] io_configs_en;
   logic [IDX_W-1:0]     io_word_idx;
   logic                 io_busy;
   logic                 io_done;
   logic                 io_error;

   modport master (
      output io_start, io_in_valid, io_in_bits,
      input  io_in_ready, io_d_out, io_configs_en, io_word_idx,
             io_busy, io_done, io_error
   );

   modport slave (
      input  io_start, io_in_valid, io_in_bits,
      output io_in_ready, io_d_out, io_configs_en, io_word_idx,
             io_busy, io_done, io_error
   );
endinterface

// File: rtl/config_word_loader.sv
// config_word_loader
//   Loads a session of NUM_WORDS configuration words from a valid/ready
//   stream into a bank of transparent latches. Each word goes through
//   ACCEPT -> SETUP -> STROBE -> HOLD so the latch data bus is stable one
//   cycle before, during and one cycle after its enable pulse. A trailing
//   word is compared with the XOR of all data words; done/error are sticky
//   until the next start.
//   Ports:
//     clk    rising-edge clock
//     reset  asynchronous, active-high; returns to IDLE and drops enables
//     io     config_word_loader_if.slave (stream in, latch bus out, status)
module config_word_loader #(
   parameter int NUM_WORDS = 46,
   parameter int WORD_W    = 32,
   parameter int IDX_W     = 6
) (
   input  logic                 clk,
   input  logic                 reset,
   config_word_loader_if.slave  io
);

   typedef enum logic [2:0] {
      S_IDLE, S_ACCEPT, S_SETUP, S_STROBE, S_HOLD, S_CHECK
   } state_t;

   localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(NUM_WORDS - 1);
   localparam logic [NUM_WORDS-1:0] EN_ONE   = NUM_WORDS'(1);

   state_t               state, state_nxt;
   logic [IDX_W-1:0]     idx;
   logic [WORD_W-1:0]    csum;
   logic [WORD_W-1:0]    d_q;
   logic [NUM_WORDS-1:0] en_q;
   logic                 done_q, err_q;
   logic                 ready, busy, fire;

   // state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   // next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:   if (io.io_start) state_nxt = S_ACCEPT;
         S_ACCEPT: if (fire)        state_nxt = S_SETUP;
         S_SETUP:                   state_nxt = S_STROBE;
         S_STROBE:                  state_nxt = S_HOLD;
         S_HOLD:   state_nxt = (idx == LAST_IDX) ? S_CHECK : S_ACCEPT;
         S_CHECK:  if (fire)        state_nxt = S_IDLE;
         default:                   state_nxt = S_IDLE;
      endcase
   end

   // state-decoded outputs
   always_comb begin
      ready = 1'b0;
      busy  = 1'b1;
      case (state)
         S_IDLE:   busy  = 1'b0;
         S_ACCEPT: ready = 1'b1;
         S_CHECK:  ready = 1'b1;
         default:  ;
      endcase
   end

   assign fire = io.io_in_valid & ready;

   // Datapath. The enable register is loaded while in SETUP so the pulse
   // coincides exactly with STROBE and comes straight off a flop; it is
   // cleared in every other state, which bounds it to one cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         idx    <= '0;
         csum   <= '0;
         d_q    <= '0;
         en_q   <= '0;
         done_q <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         en_q <= (state == S_SETUP) ? (EN_ONE << idx) : '0;
         case (state)
            S_IDLE: if (io.io_start) begin
               idx    <= '0;
               csum   <= '0;
               done_q <= 1'b0;
               err_q  <= 1'b0;
            end
            S_ACCEPT: if (fire) begin
               d_q  <= io.io_in_bits;
               csum <= csum ^ io.io_in_bits;
            end
            // idx saturates at the last word; HOLD routes to CHECK there
            S_HOLD: if (idx != LAST_IDX) idx <= idx + IDX_W'(1);
            S_CHECK: if (fire) begin
               err_q  <= (io.io_in_bits != csum);
               done_q <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign io.io_in_ready   = ready;
   assign io.io_busy       = busy;
   assign io.io_d_out      = d_q;
   assign io.io_configs_en = en_q;
   assign io.io_word_idx   = idx;
   assign io.io_done       = done_q;
   assign io.io_error      = err_q;

endmodule

// File: tb/tb_config_word_loader.sv
// tb_config_word_loader
//   Directed table of sessions with cycle-exact expectations, hand-written
//   sequences for ignored start / mid-session reset, and random-gap sessions
//   checking the enable and data-stability invariants.
module tb_config_word_loader;
   localparam int NW = 46;
   localparam int WW = 32;
   localparam int IW = 6;
   localparam int NO_STALL = 1000;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   config_word_loader_if #(.NUM_WORDS(NW), .WORD_W(WW), .IDX_W(IW)) io();

   config_word_loader #(.NUM_WORDS(NW), .WORD_W(WW), .IDX_W(IW)) dut (
      .clk   (clk),
      .reset (reset),
      .io    (io)
   );

   int n_chk = 0;
   int n_err = 0;

   typedef struct {
      logic [31:0] base;       // word i = base + i
      logic [31:0] chk;        // trailing checksum word
      int          stall_word; // valid held low before this word (NW = checksum word)
      int          stall_len;
      logic        exp_err;
   } vec_t;

   vec_t vecs[7];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, ".ready"}, 64'(io.io_in_ready), 64'd0);
      chk({tag, ".d_out"}, 64'(io.io_d_out), 64'd0);
      chk({tag, ".en"},    64'(io.io_configs_en), 64'd0);
      chk({tag, ".idx"},   64'(io.io_word_idx), 64'd0);
      chk({tag, ".busy"},  64'(io.io_busy), 64'd0);
      chk({tag, ".done"},  64'(io.io_done), 64'd0);
      chk({tag, ".error"}, 64'(io.io_error), 64'd0);
   endtask

   // Cycle c is observed 1 time unit after the c-th edge following start.
   // Word k (k = NW is the checksum) is accepted at a[k] = 4k+1 (+ stall).
   task automatic run_vec(input vec_t v);
      int a[NW+1];
      int sw_lo, sw_hi, last;
      logic [NW-1:0] exp_en;
      logic exp_rdy;
      for (int k = 0; k <= NW; k++)
         a[k] = 4*k + 1 + ((k >= v.stall_word) ? v.stall_len : 0);
      sw_lo = 4*v.stall_word + 1;
      sw_hi = sw_lo + v.stall_len;
      last  = a[NW];
      io.io_in_valid = 1'b0;
      io.io_start    = 1'b1;
      tick;
      io.io_start = 1'b0;
      for (int c = 1; c <= last + 1; c++) begin
         io.io_in_valid = !(c >= sw_lo && c < sw_hi);
         io.io_in_bits  = v.chk;
         for (int k = NW-1; k >= 0; k--)
            if (c <= a[k]) io.io_in_bits = v.base + 32'(k);
         exp_en  = '0;
         exp_rdy = (c >= sw_lo && c < sw_hi);
         for (int k = 0; k <= NW; k++)
            if (c == a[k]) exp_rdy = 1'b1;
         for (int k = 0; k < NW; k++)
            if (c == a[k] + 2) exp_en[k] = 1'b1;
         if (c == 1) begin
            chk("start_clears_done", 64'(io.io_done), 64'd0);
            chk("start_clears_error", 64'(io.io_error), 64'd0);
         end
         if (c <= last) begin
            chk("en", 64'(io.io_configs_en), 64'(exp_en));
            chk("ready", 64'(io.io_in_ready), 64'(exp_rdy));
            chk("busy", 64'(io.io_busy), 64'd1);
            for (int k = 0; k < NW; k++) begin
               if (c > a[k] && c <= a[k+1])
                  chk("d_out", 64'(io.io_d_out), 64'(v.base + 32'(k)));
               if (c == a[k] + 2)
                  chk("idx", 64'(io.io_word_idx), 64'(k));
            end
         end else begin
            chk("done", 64'(io.io_done), 64'd1);
            chk("error", 64'(io.io_error), 64'(v.exp_err));
            chk("end_busy", 64'(io.io_busy), 64'd0);
            chk("end_ready", 64'(io.io_in_ready), 64'd0);
            chk("end_en", 64'(io.io_configs_en), 64'd0);
         end
         tick;
      end
      io.io_in_valid = 1'b0;
      repeat (5) tick;
      chk("sticky_done", 64'(io.io_done), 64'd1);
      chk("sticky_error", 64'(io.io_error), 64'(v.exp_err));
      chk("idle_busy", 64'(io.io_busy), 64'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [NW-1:0] e;
      // words base+i for i=0..45 never carry, so the XOR is base^...^base
      // (even count, cancels) XOR (0^1^...^45) = 1
      vecs[0] = '{32'h1000_0000, 32'h0000_0001, NO_STALL, 0, 1'b0};
      vecs[1] = '{32'h1000_0000, 32'h0000_0000, NO_STALL, 0, 1'b1};
      vecs[2] = '{32'h1000_0000, 32'h0000_0001, 10,       5, 1'b0};
      vecs[3] = '{32'hA5A5_0000, 32'h0000_0001, 0,        3, 1'b0};
      vecs[4] = '{32'h0F0F_0F00, 32'h0000_0001, NW,       4, 1'b0};
      vecs[5] = '{32'hFFFF_FF00, 32'h0000_0001, 45,       2, 1'b0};
      vecs[6] = '{32'h0F0F_0F00, 32'h8000_0001, NO_STALL, 0, 1'b1};

      io.io_start    = 1'b0;
      io.io_in_valid = 1'b0;
      io.io_in_bits  = '0;
      #2;
      chk_reset_vals("por");
      @(negedge clk);
      reset = 1'b0;
      tick;
      chk_reset_vals("idle");

      for (int i = 0; i < 7; i++) run_vec(vecs[i]);

      // ignored start at cycle 50, then reset while word 24 is strobing
      io.io_in_valid = 1'b1;
      io.io_in_bits  = 32'h2000_0000;
      io.io_start    = 1'b1;
      tick;
      io.io_start = 1'b0;
      for (int c = 1; c <= 99; c++) begin
         io.io_in_bits = 32'h2000_0000 + 32'((c-1)/4);
         io.io_start   = (c == 50);
         e = '0;
         if (c == 51) begin
            e[12] = 1'b1;
            chk("ign_start.en12", 64'(io.io_configs_en), 64'(e));
            chk("ign_start.d12", 64'(io.io_d_out), 64'h2000_000C);
         end
         if (c == 55) begin
            e[13] = 1'b1;
            chk("ign_start.en13", 64'(io.io_configs_en), 64'(e));
            chk("ign_start.idx13", 64'(io.io_word_idx), 64'd13);
         end
         if (c == 99) begin
            e[24] = 1'b1;
            chk("pre_rst.en24", 64'(io.io_configs_en), 64'(e));
         end
         if (c < 99) tick;
      end
      io.io_start = 1'b0;
      #3 reset = 1'b1;
      #1 chk_reset_vals("midrst");
      #1 reset = 1'b0;
      tick;
      chk("post_rst.busy", 64'(io.io_busy), 64'd0);
      chk("post_rst.ready", 64'(io.io_in_ready), 64'd0);
      chk("post_rst.en", 64'(io.io_configs_en), 64'd0);
      run_vec(vecs[0]);

      // random valid gaps; stream protocol tracked by the bench
      for (int s = 0; s < 20; s++) begin
         logic [31:0] cur, xacc, last_w, pd;
         logic [NW-1:0] pen, ee;
         int cnt;
         bit fin;
         cnt = 0; xacc = '0; last_w = '0; fin = 1'b0;
         cur = $urandom;
         io.io_in_valid = 1'b0;
         io.io_start    = 1'b1;
         tick;
         io.io_start = 1'b0;
         pen = '0;
         pd  = io.io_d_out;
         for (int c = 0; c < 2000 && !fin; c++) begin
            io.io_in_valid = ($urandom_range(0, 3) != 0);
            io.io_in_bits  = (cnt == NW) ? xacc : cur;
            chk("rnd.onehot0", 64'($onehot0(io.io_configs_en)), 64'd1);
            if (io.io_configs_en != '0) begin
               ee = '0;
               if (cnt > 0) ee[cnt-1] = 1'b1;
               chk("rnd.en", 64'(io.io_configs_en), 64'(ee));
               chk("rnd.d_out", 64'(io.io_d_out), 64'(last_w));
               if (pen == '0) chk("rnd.setup_stable", 64'(io.io_d_out), 64'(pd));
            end else if (pen != '0) begin
               chk("rnd.hold_stable", 64'(io.io_d_out), 64'(pd));
            end
            if (io.io_in_valid && io.io_in_ready) begin
               if (cnt == NW) fin = 1'b1;
               else begin
                  xacc   = xacc ^ cur;
                  last_w = cur;
                  cnt++;
                  cur = $urandom;
               end
            end
            pen = io.io_configs_en;
            pd  = io.io_d_out;
            tick;
         end
         io.io_in_valid = 1'b0;
         chk("rnd.finished", 64'(fin), 64'd1);
         chk("rnd.done", 64'(io.io_done), 64'd1);
         chk("rnd.error", 64'(io.io_error), 64'd0);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
